// File: rtl/gpr_writeback_if.sv
// Write-request bus for gpr_writeback: one ALU-source and one load-source channel.
interface gpr_writeback_if;
   logic        alu_valid;
   logic        alu_ready;
   logic [4:0]  alu_reg;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_reg;
   logic [31:0] mem_data;

   modport master (
      output alu_valid, alu_reg, alu_data,
      output mem_valid, mem_reg, mem_data,
      input  alu_ready, mem_ready
   );

   modport slave (
      input  alu_valid, alu_reg, alu_data,
      input  mem_valid, mem_reg, mem_data,
      output alu_ready, mem_ready
   );
endinterface

// File: rtl/gpr_writeback.sv
// GPR write-back arbiter: merges ALU results and queued load data into a single
// registered register-file write port. ALU writes take priority; loads wait in a
// DEPTH-entry FIFO. Destination r0 requests are accepted and dropped.
// Optional read bypass from the output stage is enabled by GPR_WRITEBACK_BYPASS_EN.
module gpr_writeback #(
   parameter int unsigned DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   gpr_writeback_if.slave bus,
   output logic         rw,
   output logic [4:0]   WriteReg,
   output logic [31:0]  WriteData,
   output logic [4:0]   pending,
   input  logic [4:0]   ReadReg1,
   input  logic [4:0]   ReadReg2,
   input  logic [31:0]  ReadData1,
   input  logic [31:0]  ReadData2,
   output logic [31:0]  FwdData1,
   output logic [31:0]  FwdData2
);

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 5;
   localparam int unsigned PTR_W  = $clog2(DEPTH);

   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   wb_entry_t          queue_q [DEPTH];
   wb_entry_t          queue_d [DEPTH];
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]   pending_q, pending_d;
   logic               rw_q, rw_d;
   logic [REG_W-1:0]   write_reg_q, write_reg_d;
   logic [DATA_W-1:0]  write_data_q, write_data_d;

   logic has_room;
   logic alu_acc;
   logic mem_acc;
   logic alu_issue;
   logic head_issue;
   logic enq;

   // Readiness depends only on queue occupancy; a full queue stalls both sources.
   assign has_room      = (pending_q < CNT_W'(DEPTH));
   assign bus.alu_ready = has_room;
   assign bus.mem_ready = has_room;

   // Handshakes and issue selection; r0 requests never take an issue slot or entry.
   always_comb begin
      alu_acc    = rst & bus.alu_valid & has_room;
      mem_acc    = rst & bus.mem_valid & has_room;
      alu_issue  = alu_acc & (bus.alu_reg != '0);
      head_issue = ~alu_issue & (pending_q != '0);
      enq        = mem_acc & (bus.mem_reg != '0);
   end

   // Next-state for the output stage, FIFO storage, pointers and occupancy.
   always_comb begin
      queue_d      = queue_q;
      wr_ptr_d     = wr_ptr_q;
      rd_ptr_d     = rd_ptr_q;
      rw_d         = 1'b0;
      write_reg_d  = write_reg_q;
      write_data_d = write_data_q;

      if (alu_issue) begin
         rw_d         = 1'b1;
         write_reg_d  = bus.alu_reg;
         write_data_d = bus.alu_data;
      end else if (head_issue) begin
         rw_d         = 1'b1;
         write_reg_d  = queue_q[rd_ptr_q].rd;
         write_data_d = queue_q[rd_ptr_q].data;
         rd_ptr_d     = rd_ptr_q + PTR_W'(1);
      end

      if (enq) begin
         queue_d[wr_ptr_q] = '{rd: bus.mem_reg, data: bus.mem_data};
         wr_ptr_d          = wr_ptr_q + PTR_W'(1);
      end

      pending_d = pending_q + CNT_W'(enq) - CNT_W'(head_issue);
   end

   // Control and output-stage registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         wr_ptr_q     <= '0;
         rd_ptr_q     <= '0;
         pending_q    <= '0;
         rw_q         <= 1'b0;
         write_reg_q  <= '0;
         write_data_q <= '0;
      end else begin
         wr_ptr_q     <= wr_ptr_d;
         rd_ptr_q     <= rd_ptr_d;
         pending_q    <= pending_d;
         rw_q         <= rw_d;
         write_reg_q  <= write_reg_d;
         write_data_q <= write_data_d;
      end
   end

   // FIFO storage; contents are don't-care whenever the occupancy says empty.
   always_ff @(posedge clk) begin
      queue_q <= queue_d;
   end

   assign rw        = rw_q;
   assign WriteReg  = write_reg_q;
   assign WriteData = write_data_q;
   assign pending   = pending_q;

`ifdef GPR_WRITEBACK_BYPASS_EN
   // Forward the in-flight write to a matching read port; r0 is never forwarded.
   always_comb begin
      FwdData1 = ReadData1;
      FwdData2 = ReadData2;
      if (rw_q && (write_reg_q == ReadReg1) && (ReadReg1 != '0)) FwdData1 = write_data_q;
      if (rw_q && (write_reg_q == ReadReg2) && (ReadReg2 != '0)) FwdData2 = write_data_q;
   end
`else
   // No bypass: read data passes straight through; read addresses are not needed.
   logic unused_read_regs;
   assign unused_read_regs = ^{ReadReg1, ReadReg2};
   assign FwdData1 = ReadData1;
   assign FwdData2 = ReadData2;
`endif

endmodule
